// File: rtl/vga_sync_decoder_if.sv
// Sync stream from the timing generator and the recovered position/status from the decoder.
// master = stream source / observer, slave = vga_sync_decoder.
interface vga_sync_decoder_if;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic [9:0]  pix_col;
    logic [9:0]  pix_row;
    logic        pix_valid;
    logic        line_start;
    logic        frame_start;
    logic        locked;
    logic [10:0] line_len;
    logic [10:0] frame_lines;
    logic        err_pulse;
    logic [7:0]  err_count;

    modport master (
        output hsync, vsync, video_on,
        input  pix_col, pix_row, pix_valid, line_start, frame_start,
        input  locked, line_len, frame_lines, err_pulse, err_count
    );

    modport slave (
        input  hsync, vsync, video_on,
        output pix_col, pix_row, pix_valid, line_start, frame_start,
        output locked, line_len, frame_lines, err_pulse, err_count
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA sync decoder: rebuilds pixel row/col from hsync/vsync/video_on,
// measures line/frame lengths, tracks lock and counts timing errors.
module vga_sync_decoder #(
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int H_ACTIVE        = 640,
    parameter int H_TOTAL         = 800,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int V_ACTIVE        = 480,
    parameter int V_TOTAL         = 525,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    vga_sync_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        S_WAIT_V = 2'd0,
        S_CHECK  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    localparam logic [10:0] H_START   = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_END     = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [10:0] V_START   = 11'(V_SYNC + V_BP);
    localparam logic [10:0] V_END     = 11'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [10:0] LINE_NOM  = 11'(H_TOTAL);
    localparam logic [10:0] FRAME_NOM = 11'(V_TOTAL);
    localparam logic [10:0] CNT_MAX   = '1;

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == CNT_MAX) ? v : v + 11'd1;
    endfunction

    // Input stage, normalised to active-high
    logic r_hs, r_hs_d, r_vs, r_vs_d, r_von;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs   <= 1'b0;
            r_hs_d <= 1'b0;
            r_vs   <= 1'b0;
            r_vs_d <= 1'b0;
            r_von  <= 1'b0;
        end else begin
            r_hs   <= bus.hsync ^ SYNC_ACTIVE_LOW;
            r_vs   <= bus.vsync ^ SYNC_ACTIVE_LOW;
            r_von  <= bus.video_on;
            r_hs_d <= r_hs;
            r_vs_d <= r_vs;
        end
    end

    logic        r_armed;
    logic [10:0] r_h_cnt, r_v_cnt;
    logic        r_v_pend;
    logic [9:0]  r_pix_col, r_pix_row;
    logic        r_pix_valid, r_line_start, r_frame_start, r_locked;
    logic [10:0] r_line_len, r_frame_lines;
    logic        r_err_pulse;
    logic [7:0]  r_err_count;
    state_t      r_state;
    logic        r_seen_fs;

    logic        w_hs_edge, w_vs_edge, w_fs;
    logic [10:0] w_h_nxt, w_v_nxt, w_len_nxt, w_lines_nxt;
    logic        w_valid, w_timeout;
    state_t      w_state_nxt;
    logic        w_seen_nxt, w_err;

    assign w_hs_edge   = r_hs & ~r_hs_d;
    assign w_vs_edge   = r_vs & ~r_vs_d;
    assign w_fs        = w_hs_edge & (r_v_pend | w_vs_edge);
    assign w_len_nxt   = sat_inc(r_h_cnt);
    assign w_lines_nxt = sat_inc(r_v_cnt);

    // Counts describe the sample now in the input register, so outputs can be registered directly
    assign w_h_nxt = w_hs_edge ? '0 : sat_inc(r_h_cnt);
    assign w_v_nxt = w_fs ? '0 : (w_hs_edge ? sat_inc(r_v_cnt) : r_v_cnt);

    assign w_valid = (w_h_nxt >= H_START) && (w_h_nxt <= H_END) &&
                     (w_v_nxt >= V_START) && (w_v_nxt <= V_END);

    // Fires only on the cycle the counter first hits its ceiling
    assign w_timeout = (w_h_nxt == CNT_MAX) && (r_h_cnt != CNT_MAX);

    always_comb begin
        w_state_nxt = r_state;
        w_seen_nxt  = r_seen_fs;
        w_err       = 1'b0;
        if (r_armed) begin
            case (r_state)
                S_WAIT_V: begin
                    if (w_fs) begin
                        w_state_nxt = S_CHECK;
                        w_seen_nxt  = 1'b1;
                    end
                end
                S_CHECK: begin
                    if (w_timeout || (w_hs_edge && (w_len_nxt != LINE_NOM))) begin
                        w_err       = 1'b1;
                        w_state_nxt = S_WAIT_V;
                    end else if (w_fs) begin
                        // A frame entered mid-way from LOCKED is only a start marker
                        if (!r_seen_fs) begin
                            w_seen_nxt = 1'b1;
                        end else if (w_lines_nxt == FRAME_NOM) begin
                            w_state_nxt = S_LOCKED;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                end
                S_LOCKED: begin
                    if (w_timeout) begin
                        w_err       = 1'b1;
                        w_state_nxt = S_WAIT_V;
                    end else if ((w_hs_edge && (w_len_nxt != LINE_NOM)) ||
                                 (w_fs && (w_lines_nxt != FRAME_NOM)) ||
                                 (r_von != w_valid)) begin
                        w_err       = 1'b1;
                        w_state_nxt = S_CHECK;
                        w_seen_nxt  = 1'b0;
                    end
                end
                default: w_state_nxt = S_WAIT_V;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_WAIT_V;
            r_seen_fs <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_seen_fs <= w_seen_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed       <= 1'b0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_v_pend      <= 1'b0;
            r_pix_col     <= '0;
            r_pix_row     <= '0;
            r_pix_valid   <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_locked      <= 1'b0;
            r_line_len    <= '0;
            r_frame_lines <= '0;
            r_err_pulse   <= 1'b0;
            r_err_count   <= '0;
        end else if (!r_armed) begin
            // Everything stays frozen until the first vsync edge after reset
            r_armed <= w_vs_edge;
        end else begin
            r_h_cnt <= w_h_nxt;
            r_v_cnt <= w_v_nxt;
            if (w_fs) begin
                r_v_pend <= 1'b0;
            end else if (w_vs_edge) begin
                r_v_pend <= 1'b1;
            end
            if (w_hs_edge) begin
                r_line_len <= w_len_nxt;
            end
            if (w_fs) begin
                r_frame_lines <= w_lines_nxt;
            end
            r_pix_valid   <= w_valid;
            r_pix_col     <= w_valid ? 10'(w_h_nxt - H_START) : '0;
            r_pix_row     <= w_valid ? 10'(w_v_nxt - V_START) : '0;
            r_line_start  <= w_hs_edge;
            r_frame_start <= w_fs;
            r_err_pulse   <= w_err;
            if (w_err && (r_err_count != '1)) begin
                r_err_count <= r_err_count + 8'd1;
            end
            r_locked <= (r_state == S_LOCKED);
        end
    end

    assign bus.pix_col     = r_pix_col;
    assign bus.pix_row     = r_pix_row;
    assign bus.pix_valid   = r_pix_valid;
    assign bus.line_start  = r_line_start;
    assign bus.frame_start = r_frame_start;
    assign bus.locked      = r_locked;
    assign bus.line_len    = r_line_len;
    assign bus.frame_lines = r_frame_lines;
    assign bus.err_pulse   = r_err_pulse;
    assign bus.err_count   = r_err_count;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: a small-timing sync generator drives the DUT; per-sample
// position expectations are queued and compared two clocks later, status is checked at milestones.
module tb_vga_sync_decoder;

    localparam int HS  = 4;
    localparam int HBP = 3;
    localparam int HA  = 10;
    localparam int HT  = 20;
    localparam int VS  = 2;
    localparam int VBP = 2;
    localparam int VA  = 5;
    localparam int VT  = 12;
    localparam bit SAL = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_sync_decoder_if bus();

    vga_sync_decoder #(
        .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_TOTAL(VT),
        .SYNC_ACTIVE_LOW(SAL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [9:0] col;
        logic [9:0] row;
        logic       valid;
        logic       ls;
        logic       fs;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   n_err_seen = 0;
    bit   armed      = 1'b0;
    bit   last_vs    = 1'b0;
    bit   rst_q      = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t zero_exp();
        exp_t z;
        z.col   = '0;
        z.row   = '0;
        z.valid = 1'b0;
        z.ls    = 1'b0;
        z.fs    = 1'b0;
        return z;
    endfunction

    // One pixel clock: drive the sample, queue its expectation, score the one from two edges ago
    task automatic drive(input bit hs, input bit vs, input bit von, input exp_t e);
        exp_t x;
        bus.hsync    = hs ^ SAL;
        bus.vsync    = vs ^ SAL;
        bus.video_on = von;
        if (rst && !rst_q) sb_q.delete();
        rst_q = rst;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (bus.err_pulse === 1'b1) n_err_seen++;
        if (sb_q.size() >= 2) begin
            x = sb_q.pop_front();
            check_eq("pix_col",     bus.pix_col,     x.col);
            check_eq("pix_row",     bus.pix_row,     x.row);
            check_eq("pix_valid",   bus.pix_valid,   x.valid);
            check_eq("line_start",  bus.line_start,  x.ls);
            check_eq("frame_start", bus.frame_start, x.fs);
        end
    endtask

    task automatic pixel(input int h, input int v);
        bit   hs, vs, von;
        exp_t e;
        hs  = (h < HS);
        vs  = (v < VS);
        von = (h >= HS + HBP) && (h < HS + HBP + HA) && (v >= VS + VBP) && (v < VS + VBP + VA);
        e   = zero_exp();
        if (rst) begin
            armed = 1'b0;
        end else if (!armed) begin
            if (vs && !last_vs) armed = 1'b1;
        end else begin
            e.valid = von;
            e.col   = von ? 10'(h - HS - HBP) : '0;
            e.row   = von ? 10'(v - VS - VBP) : '0;
            e.ls    = (h == 0);
            e.fs    = (h == 0) && (v == 0);
        end
        last_vs = rst ? 1'b0 : vs;
        drive(hs, vs, von, e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 1'b0, zero_exp());
        end
        last_vs = 1'b0;
    endtask

    task automatic line(input int v, input int h0, input int h1);
        for (int h = h0; h < h1; h++) pixel(h, v);
    endtask

    task automatic frame(input int short_v);
        for (int v = 0; v < VT; v++) line(v, 0, (v == short_v) ? HT - 1 : HT);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".pix_col"},     bus.pix_col,     0);
        check_eq({tag, ".pix_row"},     bus.pix_row,     0);
        check_eq({tag, ".pix_valid"},   bus.pix_valid,   0);
        check_eq({tag, ".line_start"},  bus.line_start,  0);
        check_eq({tag, ".frame_start"}, bus.frame_start, 0);
        check_eq({tag, ".locked"},      bus.locked,      0);
        check_eq({tag, ".line_len"},    bus.line_len,    0);
        check_eq({tag, ".frame_lines"}, bus.frame_lines, 0);
        check_eq({tag, ".err_pulse"},   bus.err_pulse,   0);
        check_eq({tag, ".err_count"},   bus.err_count,   0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time %0t reached, required end of test earlier", $time);
        $fatal(1);
    end

    initial begin
        // Reset state
        rst = 1'b1;
        idle(1);
        check_all_zero("reset");
        idle(2);
        rst = 1'b0;

        // Partial frame before any vsync edge: nothing may change
        for (int v = 6; v < VT; v++) line(v, 0, HT);
        check_eq("prearm.line_len", bus.line_len, 0);
        check_eq("prearm.locked",   bus.locked,   0);

        // Nominal stream: arm on 1st vsync, frame_start on 2nd, lock one frame later
        frame(-1);
        check_eq("frameA.locked",      bus.locked,      0);
        check_eq("frameA.frame_lines", bus.frame_lines, 0);
        frame(-1);
        check_eq("frameB.locked",      bus.locked,      0);
        check_eq("frameB.frame_lines", bus.frame_lines, VT);
        line(0, 0, HT);
        check_eq("frameC.locked", bus.locked, 1);
        for (int v = 1; v < VT; v++) line(v, 0, HT);
        frame(-1);
        check_eq("nominal.line_len",    bus.line_len,    HT);
        check_eq("nominal.frame_lines", bus.frame_lines, VT);
        check_eq("nominal.err_count",   bus.err_count,   0);
        check_eq("nominal.err_pulses",  n_err_seen,      0);
        check_eq("nominal.locked",      bus.locked,      1);

        // One short line while locked
        frame(6);
        check_eq("short.err_pulses", n_err_seen,    1);
        check_eq("short.err_count",  bus.err_count, 1);
        check_eq("short.locked",     bus.locked,    0);
        frame(-1);
        check_eq("short.relock_early", bus.locked, 0);
        line(0, 0, HT);
        check_eq("short.relock", bus.locked, 1);
        for (int v = 1; v < VT; v++) line(v, 0, HT);

        // Hsync missing for 3000 clocks while locked
        for (int v = 0; v < 5; v++) line(v, 0, HT);
        idle(3000);
        check_eq("timeout.err_pulses", n_err_seen,    2);
        check_eq("timeout.err_count",  bus.err_count, 2);
        check_eq("timeout.locked",     bus.locked,    0);
        check_eq("timeout.line_len_held", bus.line_len, HT);
        line(5, 0, 3);
        check_eq("timeout.line_len_sat", bus.line_len, 2047);
        line(5, 3, HT);
        for (int v = 6; v < VT; v++) line(v, 0, HT);
        frame(-1);
        check_eq("timeout.wait_v_locked", bus.locked,    0);
        check_eq("timeout.no_new_err",    bus.err_count, 2);
        line(0, 0, HT);
        check_eq("timeout.relock", bus.locked, 1);

        // Reset mid-line while locked
        line(1, 0, HT);
        line(2, 0, HT);
        line(3, 0, 10);
        rst = 1'b1;
        line(3, 10, 11);
        check_all_zero("midrst");
        line(3, 11, 13);
        rst = 1'b0;
        line(3, 13, HT);
        for (int v = 4; v < VT; v++) line(v, 0, HT);
        check_eq("midrst.frozen_line_len", bus.line_len, 0);
        frame(-1);
        check_eq("midrst.arm_locked",      bus.locked,      0);
        check_eq("midrst.arm_frame_lines", bus.frame_lines, 0);
        frame(-1);
        check_eq("midrst.check_locked", bus.locked,      0);
        check_eq("midrst.frame_lines",  bus.frame_lines, VT);
        line(0, 0, HT);
        check_eq("midrst.relock",    bus.locked,    1);
        check_eq("midrst.err_count", bus.err_count, 0);
        line(1, 0, HT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
